// File: rtl/instr_excute_seq_if.sv
// Operand-fetch / execute / operand-store / control-FSM handshake bundle for instr_excute_seq.
// master = driving side (fetch, store-ready, FSM start); slave = the execute unit.
interface instr_excute_seq_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 5
);
    logic              fsm_ie_en;
    logic              ie_fsm_ready;
    logic [OP_W-1:0]   of_ie_operation;
    logic [DATA_W-1:0] of_ie_operand_des;
    logic [DATA_W-1:0] of_ie_operand_des_high;
    logic [DATA_W-1:0] of_ie_operand_sou;
    logic [DATA_W-1:0] of_ie_operand_sou_high;
    logic [7:0]        of_ie_flag_reg;
    logic [DATA_W-1:0] ie_os_result;
    logic [DATA_W-1:0] ie_os_result_high;
    logic [7:0]        ie_os_flag_reg;
    logic              ie_os_valid;
    logic              os_ie_ready;
    logic [7:0]        ie_fsm_flag_reg;
    logic              ie_os_illegal;

    modport master (
        output fsm_ie_en, of_ie_operation, of_ie_operand_des, of_ie_operand_des_high,
               of_ie_operand_sou, of_ie_operand_sou_high, of_ie_flag_reg, os_ie_ready,
        input  ie_fsm_ready, ie_os_result, ie_os_result_high, ie_os_flag_reg,
               ie_os_valid, ie_fsm_flag_reg, ie_os_illegal
    );

    modport slave (
        input  fsm_ie_en, of_ie_operation, of_ie_operand_des, of_ie_operand_des_high,
               of_ie_operand_sou, of_ie_operand_sou_high, of_ie_flag_reg, os_ie_ready,
        output ie_fsm_ready, ie_os_result, ie_os_result_high, ie_os_flag_reg,
               ie_os_valid, ie_fsm_flag_reg, ie_os_illegal
    );
endinterface

// File: rtl/instr_excute_seq.sv
// Multi-cycle Z80-style execute unit; 16-bit pair ops run as two carry-chained slices. DAA op: INSTR_EXCUTE_DAA_EN.
// Latency: valid on the 2nd edge (8-bit/illegal) or 3rd edge (16-bit) counting the accept edge.
// Backpressure: result and flags held in DONE until os_ie_ready; starts outside IDLE are dropped.
module instr_excute_seq #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_excute_seq_if.slave     bus
);
    localparam int MSB = DATA_W - 1;
    localparam int FW  = DATA_W + 1;

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADC   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SBC   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(6);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_CP    = OP_W'(8);
    localparam logic [OP_W-1:0] OP_INC   = OP_W'(9);
    localparam logic [OP_W-1:0] OP_DEC   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ADD16 = OP_W'(11);
    localparam logic [OP_W-1:0] OP_ADC16 = OP_W'(12);
    localparam logic [OP_W-1:0] OP_SBC16 = OP_W'(13);
`ifdef INSTR_EXCUTE_DAA_EN
    localparam logic [OP_W-1:0] OP_DAA   = OP_W'(14);
    localparam logic [OP_W-1:0] OP_LAST  = OP_DAA;
`else
    localparam logic [OP_W-1:0] OP_LAST  = OP_SBC16;
`endif

    typedef enum logic [1:0] {IDLE, EXEC_LO, EXEC_HI, DONE} state_t;
    state_t state;

    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] des_q, desh_q, sou_q, souh_q;
    logic [7:0]        flg_q;
    logic              carry_lo, zero_lo;

    logic is_sub, use_c, is_incdec, is_16, legal, hi_phase;
    assign is_sub    = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP) ||
                       (op_q == OP_DEC) || (op_q == OP_SBC16);
    assign use_c     = (op_q == OP_ADC) || (op_q == OP_SBC) || (op_q == OP_ADC16) ||
                       (op_q == OP_SBC16);
    assign is_incdec = (op_q == OP_INC) || (op_q == OP_DEC);
    assign is_16     = (op_q == OP_ADD16) || (op_q == OP_ADC16) || (op_q == OP_SBC16);
    assign legal     = (op_q >= OP_ADD) && (op_q <= OP_LAST);
    assign hi_phase  = (state == EXEC_HI);

    // One shared slice adder; the high phase reuses it with the latched low-slice carry
    logic [DATA_W-1:0] a_s, b_s, sum, lres;
    logic [DATA_W:0]   full;
    logic [4:0]        nib;
    logic              cin, cout, hc, ov;

    always_comb begin
        a_s = hi_phase ? desh_q : des_q;
        b_s = is_incdec ? DATA_W'(1) : (hi_phase ? souh_q : sou_q);
        cin = hi_phase ? carry_lo : (use_c & flg_q[0]);
        if (is_sub) begin
            full = {1'b0, a_s} - {1'b0, b_s} - FW'(cin);
            nib  = {1'b0, a_s[3:0]} - {1'b0, b_s[3:0]} - 5'(cin);
        end else begin
            full = {1'b0, a_s} + {1'b0, b_s} + FW'(cin);
            nib  = {1'b0, a_s[3:0]} + {1'b0, b_s[3:0]} + 5'(cin);
        end
        sum  = full[MSB:0];
        cout = full[DATA_W];
        hc   = nib[4];
        ov   = (is_sub ? (a_s[MSB] ^ b_s[MSB]) : ~(a_s[MSB] ^ b_s[MSB])) & (sum[MSB] ^ a_s[MSB]);
        if (op_q == OP_AND)     lres = des_q & sou_q;
        else if (op_q == OP_OR) lres = des_q | sou_q;
        else                    lres = des_q ^ sou_q;
    end

`ifdef INSTR_EXCUTE_DAA_EN
    logic [7:0] daa_a, daa_corr, daa_r;
    logic       daa_c, daa_h;
`endif

    logic [DATA_W-1:0] nxt_res;
    logic [7:0]        nxt_flg;

    // Flag bits: S Z 5 H 3 PV N C
    always_comb begin
        nxt_res = sum;
        nxt_flg = flg_q;
`ifdef INSTR_EXCUTE_DAA_EN
        daa_a    = des_q[7:0];
        daa_corr = 8'h00;
        daa_c    = flg_q[0];
        if (flg_q[4] || (daa_a[3:0] > 4'd9)) daa_corr[3:0] = 4'h6;
        if (flg_q[0] || (daa_a > 8'h99)) begin
            daa_corr[7:4] = 4'h6;
            daa_c         = 1'b1;
        end
        daa_r = flg_q[1] ? (daa_a - daa_corr) : (daa_a + daa_corr);
        daa_h = flg_q[1] ? (flg_q[4] && (daa_a[3:0] < 4'd6)) : (daa_a[3:0] > 4'd9);
`endif
        case (op_q)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC, OP_DEC:
                nxt_flg = {sum[MSB], (sum == '0), sum[5], hc, sum[3], ov, is_sub,
                           is_incdec ? flg_q[0] : cout};
            OP_CP: begin
                nxt_res = des_q;
                nxt_flg = {sum[MSB], (sum == '0), sou_q[5], hc, sou_q[3], ov, 1'b1, cout};
            end
            OP_AND, OP_OR, OP_XOR: begin
                nxt_res = lres;
                nxt_flg = {lres[MSB], (lres == '0), lres[5], (op_q == OP_AND), lres[3],
                           ~^lres, 2'b00};
            end
            OP_ADD16:
                nxt_flg = {flg_q[7:6], sum[5], hc, sum[3], flg_q[2], 1'b0, cout};
            OP_ADC16, OP_SBC16:
                nxt_flg = {sum[MSB], zero_lo & (sum == '0), sum[5], hc, sum[3], ov, is_sub, cout};
`ifdef INSTR_EXCUTE_DAA_EN
            OP_DAA: begin
                nxt_res      = des_q;
                nxt_res[7:0] = daa_r;
                nxt_flg      = {nxt_res[MSB], (nxt_res == '0), nxt_res[5], daa_h, nxt_res[3],
                                ~^daa_r, flg_q[1], daa_c};
            end
`endif
            default: nxt_res = des_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            op_q                  <= '0;
            des_q                 <= '0;
            desh_q                <= '0;
            sou_q                 <= '0;
            souh_q                <= '0;
            flg_q                 <= '0;
            carry_lo              <= 1'b0;
            zero_lo               <= 1'b0;
            bus.ie_fsm_ready      <= 1'b1;
            bus.ie_os_result      <= '0;
            bus.ie_os_result_high <= '0;
            bus.ie_os_flag_reg    <= '0;
            bus.ie_fsm_flag_reg   <= '0;
            bus.ie_os_valid       <= 1'b0;
            bus.ie_os_illegal     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.fsm_ie_en) begin
                        op_q             <= bus.of_ie_operation;
                        des_q            <= bus.of_ie_operand_des;
                        desh_q           <= bus.of_ie_operand_des_high;
                        sou_q            <= bus.of_ie_operand_sou;
                        souh_q           <= bus.of_ie_operand_sou_high;
                        flg_q            <= bus.of_ie_flag_reg;
                        bus.ie_fsm_ready <= 1'b0;
                        state            <= EXEC_LO;
                    end
                end
                EXEC_LO: begin
                    if (is_16) begin
                        bus.ie_os_result <= sum;
                        carry_lo         <= cout;
                        zero_lo          <= (sum == '0);
                        state            <= EXEC_HI;
                    end else begin
                        bus.ie_os_result      <= nxt_res;
                        bus.ie_os_result_high <= desh_q;
                        bus.ie_os_flag_reg    <= nxt_flg;
                        bus.ie_fsm_flag_reg   <= nxt_flg;
                        bus.ie_os_illegal     <= ~legal;
                        bus.ie_os_valid       <= 1'b1;
                        state                 <= DONE;
                    end
                end
                EXEC_HI: begin
                    bus.ie_os_result_high <= nxt_res;
                    bus.ie_os_flag_reg    <= nxt_flg;
                    bus.ie_fsm_flag_reg   <= nxt_flg;
                    bus.ie_os_valid       <= 1'b1;
                    state                 <= DONE;
                end
                DONE: begin
                    if (bus.os_ie_ready) begin
                        bus.ie_os_valid   <= 1'b0;
                        bus.ie_os_illegal <= 1'b0;
                        bus.ie_fsm_ready  <= 1'b1;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_excute_seq.sv
// Directed self-checking bench for instr_excute_seq: per-scenario tasks with hand-computed vectors.
module tb_instr_excute_seq;
    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    instr_excute_seq_if #(.DATA_W(8), .OP_W(5)) bus ();

    instr_excute_seq #(.DATA_W(8), .OP_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {valid, illegal, result_high, result, flags, fsm_flags}
    function automatic logic [33:0] snap();
        return {bus.ie_os_valid, bus.ie_os_illegal, bus.ie_os_result_high,
                bus.ie_os_result, bus.ie_os_flag_reg, bus.ie_fsm_flag_reg};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for a single accept edge, then scrambles the inputs.
    task automatic issue(input logic [4:0] op, input logic [7:0] d, input logic [7:0] dh,
                         input logic [7:0] s, input logic [7:0] sh, input logic [7:0] f);
        bus.of_ie_operation        = op;
        bus.of_ie_operand_des      = d;
        bus.of_ie_operand_des_high = dh;
        bus.of_ie_operand_sou      = s;
        bus.of_ie_operand_sou_high = sh;
        bus.of_ie_flag_reg         = f;
        bus.fsm_ie_en              = 1'b1;
        step();
        bus.fsm_ie_en              = 1'b0;
        bus.of_ie_operation        = 5'($urandom);
        bus.of_ie_operand_des      = 8'($urandom);
        bus.of_ie_operand_des_high = 8'($urandom);
        bus.of_ie_operand_sou      = 8'($urandom);
        bus.of_ie_operand_sou_high = 8'($urandom);
        bus.of_ie_flag_reg         = 8'($urandom);
    endtask

    task automatic test_reset();
        logic [33:0] obs;
        reset = 1'b1;
        #2 reset = 1'b0;
        step();
        step();
        obs = snap();
        n_checks++;
        if (obs !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want %h", obs, 34'h0);
        end
        n_checks++;
        if (bus.ie_fsm_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, want 1", bus.ie_fsm_ready);
        end
        #3 reset = 1'b1;
        step();
    endtask

    task automatic test_add();
        logic [33:0] obs;
        issue(5'd1, 8'd125, 8'h33, 8'd100, 8'h44, 8'h00);
        n_checks++;
        if ({bus.ie_os_valid, bus.ie_fsm_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL add_early: valid/ready got %b, want 00", {bus.ie_os_valid, bus.ie_fsm_ready});
        end
        step();
        obs = snap();
        n_checks++;
        if (obs !== {1'b1, 1'b0, 8'h33, 8'hE1, 8'hB4, 8'hB4}) begin
            n_fail++;
            $display("FAIL add_result: got %h, want %h", obs, {1'b1, 1'b0, 8'h33, 8'hE1, 8'hB4, 8'hB4});
        end
        step();
        n_checks++;
        if ({bus.ie_os_valid, bus.ie_fsm_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL add_handshake: valid/ready got %b, want 01", {bus.ie_os_valid, bus.ie_fsm_ready});
        end
    endtask

    task automatic test_sub_family();
        logic [33:0] obs;
        issue(5'd4, 8'd124, 8'h00, 8'd124, 8'h00, 8'hFF);
        step();
        obs = snap();
        n_checks++;
        if (obs !== {1'b1, 1'b0, 8'h00, 8'hFF, 8'hBB, 8'hBB}) begin
            n_fail++;
            $display("FAIL sbc: got %h, want %h", obs, {1'b1, 1'b0, 8'h00, 8'hFF, 8'hBB, 8'hBB});
        end
        step();
        issue(5'd3, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00);
        step();
        obs = snap();
        n_checks++;
        if (obs !== {1'b1, 1'b0, 8'h00, 8'h80, 8'h87, 8'h87}) begin
            n_fail++;
            $display("FAIL sub_ovf: got %h, want %h", obs, {1'b1, 1'b0, 8'h00, 8'h80, 8'h87, 8'h87});
        end
        step();
        issue(5'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        obs = snap();
        n_checks++;
        if (obs !== {1'b1, 1'b0, 8'h00, 8'h00, 8'h42, 8'h42}) begin
            n_fail++;
            $display("FAIL sub_zero: got %h, want %h", obs, {1'b1, 1'b0, 8'h00, 8'h00, 8'h42, 8'h42});
        end
        step();
        issue(5'd8, 8'h20, 8'h11, 8'h28, 8'h00, 8'h00);
        step();
        obs = snap();
        n_checks++;
        if (obs !== {1'b1, 1'b0, 8'h11, 8'h20, 8'hBB, 8'hBB}) begin
            n_fail++;
            $display("FAIL cp: got %h, want %h", obs, {1'b1, 1'b0, 8'h11, 8'h20, 8'hBB, 8'hBB});
        end
        step();
    endtask

    task automatic test_logic_incdec();
        logic [33:0] obs;
        issue(5'd5, 8'h0F, 8'h00, 8'h3C, 8'h00, 8'h01);
        step();
        obs = snap();
        n_checks++;
        if (obs !== {1'b1, 1'b0, 8'h00, 8'h0C, 8'h1C, 8'h1C}) begin
            n_fail++;
            $display("FAIL and: got %h, want %h", obs, {1'b1, 1'b0, 8'h00, 8'h0C, 8'h1C, 8'h1C});
        end
        step();
        issue(5'd9, 8'h7F, 8'h00, 8'hAA, 8'h00, 8'h01);
        step();
        obs = snap();
        n_checks++;
        if (obs !== {1'b1, 1'b0, 8'h00, 8'h80, 8'h95, 8'h95}) begin
            n_fail++;
            $display("FAIL inc: got %h, want %h", obs, {1'b1, 1'b0, 8'h00, 8'h80, 8'h95, 8'h95});
        end
        step();
    endtask

    task automatic test_pair_ops();
        logic [33:0] obs;
        issue(5'd11, 8'hFF, 8'h0F, 8'h01, 8'h00, 8'h00);
        step();
        n_checks++;
        if (bus.ie_os_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add16_early: valid got %b, want 0", bus.ie_os_valid);
        end
        step();
        obs = snap();
        n_checks++;
        if (obs !== {1'b1, 1'b0, 8'h10, 8'h00, 8'h10, 8'h10}) begin
            n_fail++;
            $display("FAIL add16: got %h, want %h", obs, {1'b1, 1'b0, 8'h10, 8'h00, 8'h10, 8'h10});
        end
        step();
        issue(5'd13, 8'h00, 8'h10, 8'h01, 8'h00, 8'h01);
        step();
        step();
        obs = snap();
        n_checks++;
        if (obs !== {1'b1, 1'b0, 8'h0F, 8'hFE, 8'h1A, 8'h1A}) begin
            n_fail++;
            $display("FAIL sbc16: got %h, want %h", obs, {1'b1, 1'b0, 8'h0F, 8'hFE, 8'h1A, 8'h1A});
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [33:0] obs;
        bus.os_ie_ready = 1'b0;
        issue(5'd6, 8'h50, 8'h00, 8'h05, 8'h00, 8'hFF);
        step();
        for (int i = 0; i < 5; i++) begin
            bus.fsm_ie_en       = 1'b1;
            bus.of_ie_operation = 5'd1;
            step();
            obs = snap();
            n_checks++;
            if ({obs, bus.ie_fsm_ready} !== {1'b1, 1'b0, 8'h00, 8'h55, 8'h04, 8'h04, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: got %h, want %h", i, {obs, bus.ie_fsm_ready},
                         {1'b1, 1'b0, 8'h00, 8'h55, 8'h04, 8'h04, 1'b0});
            end
        end
        bus.fsm_ie_en   = 1'b0;
        bus.os_ie_ready = 1'b1;
        step();
        n_checks++;
        if ({bus.ie_os_valid, bus.ie_fsm_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_release: valid/ready got %b, want 01", {bus.ie_os_valid, bus.ie_fsm_ready});
        end
        step();
        n_checks++;
        if ({bus.ie_os_valid, bus.ie_fsm_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_no_queue: valid/ready got %b, want 01", {bus.ie_os_valid, bus.ie_fsm_ready});
        end
    endtask

    task automatic test_reset_mid_op();
        logic [33:0] obs;
        issue(5'd11, 8'h34, 8'h12, 8'h11, 8'h11, 8'hC5);
        step();
        #2 reset = 1'b0;
        #1;
        obs = snap();
        n_checks++;
        if ({obs, bus.ie_fsm_ready} !== {34'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid: got %h, want %h", {obs, bus.ie_fsm_ready}, {34'h0, 1'b1});
        end
        #2 reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({bus.ie_os_valid, bus.ie_fsm_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_discard: valid/ready got %b, want 01", {bus.ie_os_valid, bus.ie_fsm_ready});
        end
    endtask

    task automatic test_illegal();
        logic [33:0] obs;
        issue(5'd31, 8'h5A, 8'hA5, 8'h77, 8'h66, 8'h3C);
        step();
        obs = snap();
        n_checks++;
        if (obs !== {1'b1, 1'b1, 8'hA5, 8'h5A, 8'h3C, 8'h3C}) begin
            n_fail++;
            $display("FAIL illegal31: got %h, want %h", obs, {1'b1, 1'b1, 8'hA5, 8'h5A, 8'h3C, 8'h3C});
        end
        step();
        n_checks++;
        if ({bus.ie_os_valid, bus.ie_os_illegal} !== 2'b00) begin
            n_fail++;
            $display("FAIL illegal_clear: valid/illegal got %b, want 00", {bus.ie_os_valid, bus.ie_os_illegal});
        end
        issue(5'd14, 8'h9A, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        obs = snap();
        n_checks++;
`ifdef INSTR_EXCUTE_DAA_EN
        if (obs !== {1'b1, 1'b0, 8'h00, 8'h00, 8'h55, 8'h55}) begin
            n_fail++;
            $display("FAIL daa: got %h, want %h", obs, {1'b1, 1'b0, 8'h00, 8'h00, 8'h55, 8'h55});
        end
`else
        if (obs !== {1'b1, 1'b1, 8'h00, 8'h9A, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL op14_illegal: got %h, want %h", obs, {1'b1, 1'b1, 8'h00, 8'h9A, 8'h00, 8'h00});
        end
`endif
        step();
    endtask

    initial begin
        reset                      = 1'b1;
        bus.fsm_ie_en              = 1'b0;
        bus.os_ie_ready            = 1'b1;
        bus.of_ie_operation        = '0;
        bus.of_ie_operand_des      = '0;
        bus.of_ie_operand_des_high = '0;
        bus.of_ie_operand_sou      = '0;
        bus.of_ie_operand_sou_high = '0;
        bus.of_ie_flag_reg         = '0;
        test_reset();
        test_add();
        test_sub_family();
        test_logic_incdec();
        test_pair_ops();
        test_backpressure();
        test_reset_mid_op();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
